// File: rtl/acs_frame_scheduler_if.sv
// Bundle of all scheduler-facing handshake and bus signals (BM unit, ACS array, survivor memory, traceback).
// Signal names carry the scheduler's point of view: *_i are driven into the scheduler, *_o come out of it.
// master = the scheduler itself, slave = the surrounding datapath / environment.
interface acs_frame_scheduler_if #(
  parameter int WIDTH_BM = 9,
  parameter int FRAME_W  = 10
);
  // frame control
  logic                       en_i;
  logic                       start_i;
  logic [FRAME_W-1:0]         frame_len_i;
  logic                       tail_biting_en_i;
  // branch-metric unit
  logic                       bm_valid_i;
  logic                       bm_ready_o;
  logic                       replay_o;
  // ACS array
  logic                       acs_en_o;
  logic                       acs_bm_valid_o;
  logic [1:0]                 register_num_o;
  logic                       acs_valid_i;
  logic signed [WIDTH_BM-1:0] pm_max_i;
  logic                       norm_o;
  // survivor-path memory
  logic                       sp_wr_en_o;
  logic [FRAME_W-1:0]         sp_wr_addr_o;
  // traceback and status
  logic                       tb_start_o;
  logic                       tb_done_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       err_o;

  modport master (
    input  en_i, start_i, frame_len_i, tail_biting_en_i,
    input  bm_valid_i, acs_valid_i, pm_max_i, tb_done_i,
    output bm_ready_o, replay_o, acs_en_o, acs_bm_valid_o, register_num_o, norm_o,
    output sp_wr_en_o, sp_wr_addr_o, tb_start_o, busy_o, done_o, err_o
  );

  modport slave (
    output en_i, start_i, frame_len_i, tail_biting_en_i,
    output bm_valid_i, acs_valid_i, pm_max_i, tb_done_i,
    input  bm_ready_o, replay_o, acs_en_o, acs_bm_valid_o, register_num_o, norm_o,
    input  sp_wr_en_o, sp_wr_addr_o, tb_start_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/acs_frame_scheduler.sv
// Frame sequencer for the Viterbi ACS array: gates BM symbols, rotates the PM bank, writes survivors, starts traceback.
// Latency: symbol accept is combinational; survivor write strobe and all pulses are registered, 1 cycle after their cause.
// Backpressure: bm_ready_o only in RUN, dropped for one cycle while a normalisation pulse is out; en_i low aborts at once.
module acs_frame_scheduler #(
  parameter int WIDTH_BM    = 9,
  parameter int FRAME_W     = 10,
  parameter int NORM_THRESH = 96
) (
  input  logic                  clk_i,
  input  logic                  rst_an_i,
  acs_frame_scheduler_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRAP, S_TB} state_t;

  localparam logic [FRAME_W-1:0]         ONE    = FRAME_W'(1);
  localparam logic signed [WIDTH_BM-1:0] THRESH = WIDTH_BM'(NORM_THRESH);

  state_t             state_q;
  logic [FRAME_W-1:0] len_q;
  logic               tb_en_q;
  logic               pass_q;
  logic [FRAME_W-1:0] sym_cnt_q;     // symbols accepted in this pass
  logic [FRAME_W-1:0] vld_cnt_q;     // ACS results seen in this pass
  logic [FRAME_W-1:0] wr_ptr_q;      // next survivor address to write
  logic [FRAME_W-1:0] sp_wr_addr_q;  // address of the write being strobed / last write
  logic [1:0]         register_num_q;
  logic               replay_q;
  logic               norm_q;
  logic               sp_wr_en_q;
  logic               tb_start_q;
  logic               done_q;
  logic               err_q;

  logic               bm_ready_d;
  logic               accept_d;
  logic               last_sym_d;
  logic               last_vld_d;
  logic               norm_d;
  logic               sp_wr_en_d;
  logic [FRAME_W-1:0] len_m1_d;
  logic [FRAME_W-1:0] wr_ptr_d;

  // Handshake decode and next values for the counters; a pending norm pulse blocks the next symbol.
  always_comb begin
    len_m1_d   = len_q - ONE;
    bm_ready_d = bus.en_i & (state_q == S_RUN) & ~norm_q;
    accept_d   = bm_ready_d & bus.bm_valid_i;
    last_sym_d = (sym_cnt_q == len_m1_d);
    last_vld_d = bus.acs_valid_i & (vld_cnt_q == len_m1_d);
    norm_d     = bus.acs_valid_i & (state_q != S_IDLE) & ($signed(bus.pm_max_i) > THRESH);
    sp_wr_en_d = bus.acs_valid_i & ((state_q == S_RUN) | (state_q == S_DRAIN));
    wr_ptr_d   = (wr_ptr_q == len_m1_d) ? '0 : wr_ptr_q + ONE;
  end

  // Frame FSM with registered pulses; reset and a dropped enable both discard the frame.
  always_ff @(posedge clk_i) begin
    if (!rst_an_i || !bus.en_i) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      tb_en_q        <= 1'b0;
      pass_q         <= 1'b0;
      sym_cnt_q      <= '0;
      vld_cnt_q      <= '0;
      wr_ptr_q       <= '0;
      sp_wr_addr_q   <= '0;
      register_num_q <= 2'd0;
      replay_q       <= 1'b0;
      norm_q         <= 1'b0;
      sp_wr_en_q     <= 1'b0;
      tb_start_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      replay_q   <= 1'b0;
      tb_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      norm_q     <= norm_d;
      sp_wr_en_q <= sp_wr_en_d;

      // sp_wr_addr_q keeps the written address so it still points at the last survivor in TB
      if (sp_wr_en_d) begin
        sp_wr_addr_q <= wr_ptr_q;
        wr_ptr_q     <= wr_ptr_d;
        vld_cnt_q    <= vld_cnt_q + ONE;
      end

      if (accept_d) begin
        register_num_q <= register_num_q + 2'd1;
        sym_cnt_q      <= sym_cnt_q + ONE;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.frame_len_i == '0) begin
              err_q <= 1'b1;
            end else begin
              len_q          <= bus.frame_len_i;
              tb_en_q        <= bus.tail_biting_en_i;
              pass_q         <= 1'b0;
              sym_cnt_q      <= '0;
              vld_cnt_q      <= '0;
              wr_ptr_q       <= '0;
              sp_wr_addr_q   <= '0;
              register_num_q <= 2'd0;
              state_q        <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept_d && last_sym_d) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_vld_d) begin
            if (tb_en_q && !pass_q) begin
              replay_q <= 1'b1;
              state_q  <= S_WRAP;
            end else begin
              tb_start_q <= 1'b1;
              state_q    <= S_TB;
            end
          end
        end
        S_WRAP: begin
          // second pass starts from symbol 0 with the path metrics carried over
          pass_q         <= 1'b1;
          sym_cnt_q      <= '0;
          vld_cnt_q      <= '0;
          wr_ptr_q       <= '0;
          sp_wr_addr_q   <= '0;
          register_num_q <= 2'd0;
          state_q        <= S_RUN;
        end
        S_TB: begin
          if (bus.tb_done_i) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bm_ready_o     = bm_ready_d;
  assign bus.acs_bm_valid_o = accept_d;
  assign bus.acs_en_o       = bus.en_i & (state_q != S_IDLE);
  assign bus.register_num_o = register_num_q;
  assign bus.replay_o       = replay_q;
  assign bus.norm_o         = norm_q;
  assign bus.sp_wr_en_o     = sp_wr_en_q;
  assign bus.sp_wr_addr_o   = sp_wr_addr_q;
  assign bus.tb_start_o     = tb_start_q;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.done_o         = done_q;
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_acs_frame_scheduler.sv
// Bench for acs_frame_scheduler: table of frame configurations plus hand-written abort/reset/error sequences.
// Inputs are applied 1 ns after the rising edge, outputs sampled on the falling edge.
// A one-cycle ACS stub answers every accepted symbol; expected writes and bank selects sit in queues.
module tb_acs_frame_scheduler;

  localparam int WBM         = 9;
  localparam int FW          = 10;
  localparam int NORM_THRESH = 96;

  typedef struct {
    bit rst_n;
    bit en;
    bit start;
    int len;
    bit tbe;
    bit bmv;
    bit tbd;
    int pm;
  } drv_t;

  typedef struct {
    int len;
    bit tbe;
    int pm;
    bit noise;       // hold start_i/tb_done_i high during the frame; both must be ignored
    int exp_acc;
    int exp_wr;
    int exp_replay;
    int exp_norm;
  } vec_t;

  logic clk_i;
  logic rst_an_i;

  acs_frame_scheduler_if #(.WIDTH_BM(WBM), .FRAME_W(FW)) bus ();

  acs_frame_scheduler #(.WIDTH_BM(WBM), .FRAME_W(FW), .NORM_THRESH(NORM_THRESH)) dut (
    .clk_i    (clk_i),
    .rst_an_i (rst_an_i),
    .bus      (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  drv_t drv;
  vec_t vecs[9];
  int   exp_addr_q[$];
  int   exp_rn_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_acc, n_wr, n_replay, n_norm, n_tbs, n_done, n_err;
  bit   prev_bmv = 1'b0;
  bit   exp_norm = 1'b0;
  bit   nxt_norm = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_acc = 0; n_wr = 0; n_replay = 0; n_norm = 0; n_tbs = 0; n_done = 0; n_err = 0;
  endtask

  task automatic push_frame(input int len, input bit tbe);
    for (int p = 0; p < (tbe ? 2 : 1); p++) begin
      for (int i = 0; i < len; i++) begin
        exp_addr_q.push_back(i);
        exp_rn_q.push_back(i % 4);
      end
    end
  endtask

  task automatic apply_drv();
    rst_an_i             = drv.rst_n;
    bus.en_i             = drv.en;
    bus.start_i          = drv.start;
    bus.frame_len_i      = FW'(drv.len);
    bus.tail_biting_en_i = drv.tbe;
    bus.bm_valid_i       = drv.bmv;
    bus.tb_done_i        = drv.tbd;
    // ACS stub: result one cycle after each accepted symbol
    bus.acs_valid_i      = prev_bmv;
    bus.pm_max_i         = prev_bmv ? WBM'(drv.pm) : '0;
  endtask

  task automatic monitor();
    if (bus.sp_wr_en_o === 1'b1) begin
      n_wr++;
      if (exp_addr_q.size() == 0) check("wr_unexpected", 32'(1), 32'(0));
      else check("sp_wr_addr", 32'(bus.sp_wr_addr_o), 32'(exp_addr_q.pop_front()));
    end
    if (bus.acs_bm_valid_o === 1'b1) begin
      n_acc++;
      if (exp_rn_q.size() == 0) check("acc_unexpected", 32'(1), 32'(0));
      else check("register_num", 32'(bus.register_num_o), 32'(exp_rn_q.pop_front()));
    end
    check("norm_o", 32'(bus.norm_o), 32'(exp_norm));
    if (bus.norm_o === 1'b1) begin
      n_norm++;
      check("norm_stall_ready", 32'(bus.bm_ready_o), 32'(0));
    end
    if (bus.replay_o === 1'b1)   n_replay++;
    if (bus.tb_start_o === 1'b1) n_tbs++;
    if (bus.done_o === 1'b1)     n_done++;
    if (bus.err_o === 1'b1)      n_err++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    apply_drv();
    nxt_norm = prev_bmv && (drv.pm > NORM_THRESH) && drv.en && drv.rst_n;
    @(negedge clk_i);
    monitor();
    exp_norm = nxt_norm;
    prev_bmv = bus.acs_bm_valid_o;
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({bus.busy_o, bus.acs_en_o, bus.bm_ready_o, bus.acs_bm_valid_o, bus.replay_o,
                bus.norm_o, bus.sp_wr_en_o, bus.tb_start_o, bus.done_o, bus.err_o,
                bus.register_num_o, bus.sp_wr_addr_o});
  endfunction

  task automatic run_frame(input vec_t v);
    clear_counts();
    push_frame(v.len, v.tbe);
    drv.start = 1'b1; drv.len = v.len; drv.tbe = v.tbe; drv.pm = v.pm;
    tick();
    drv.start = v.noise;
    drv.len   = v.noise ? 1 : v.len;
    drv.tbd   = v.noise;
    drv.bmv   = 1'b1;
    for (int c = 0; c < 300 && n_tbs == 0; c++) tick();
    drv.start = 1'b0; drv.tbd = 1'b0; drv.bmv = 1'b0;
    check("tb_start_count", 32'(n_tbs), 32'(1));
    check("tb_entry_addr", 32'(bus.sp_wr_addr_o), 32'(v.len - 1));
    repeat (2) tick();
    check("tb_wait_busy", 32'(bus.busy_o), 32'(!v.noise));
    check("tb_hold_addr", 32'(bus.sp_wr_addr_o), 32'(v.len - 1));
    drv.tbd = 1'b1;
    tick();
    drv.tbd = 1'b0;
    tick();
    check("done_count", 32'(n_done), 32'(1));
    check("idle_after_done", 32'(bus.busy_o), 32'(0));
    check("accept_count", 32'(n_acc), 32'(v.exp_acc));
    check("write_count", 32'(n_wr), 32'(v.exp_wr));
    check("replay_count", 32'(n_replay), 32'(v.exp_replay));
    check("norm_count", 32'(n_norm), 32'(v.exp_norm));
    check("tb_start_once", 32'(n_tbs), 32'(1));
    check("queues_drained", 32'(exp_addr_q.size() + exp_rn_q.size()), 32'(0));
  endtask

  initial begin
    // len, tbe, pm, noise, exp_acc, exp_wr, exp_replay, exp_norm
    vecs[0] = '{4, 1'b0,    0, 1'b0,  4,  4, 0,  0};
    vecs[1] = '{3, 1'b1,    0, 1'b0,  6,  6, 1,  0};
    vecs[2] = '{2, 1'b0,   97, 1'b0,  2,  2, 0,  2};
    vecs[3] = '{2, 1'b0,   96, 1'b0,  2,  2, 0,  0};
    vecs[4] = '{1, 1'b1,   -5, 1'b0,  2,  2, 1,  0};
    vecs[5] = '{5, 1'b0,  200, 1'b0,  5,  5, 0,  5};
    vecs[6] = '{3, 1'b0, -200, 1'b0,  3,  3, 0,  0};
    vecs[7] = '{6, 1'b1,    0, 1'b1, 12, 12, 1,  0};
    vecs[8] = '{5, 1'b1,  100, 1'b0, 10, 10, 1, 10};

    drv = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
    apply_drv();
    clear_counts();

    // reset state
    repeat (2) tick();
    check("reset_outputs", outs_vec(), 32'(0));
    drv.rst_n = 1'b1;
    tick();
    check("idle_outputs", outs_vec(), 32'(0));

    // frame configurations
    foreach (vecs[k]) run_frame(vecs[k]);

    // zero-length start is rejected
    clear_counts();
    drv.start = 1'b1; drv.len = 0;
    tick();
    drv.start = 1'b0;
    tick();
    check("err_pulse", 32'(bus.err_o), 32'(1));
    check("err_busy", 32'(bus.busy_o), 32'(0));
    tick();
    check("err_single", 32'(n_err), 32'(1));
    check("err_cleared", 32'(bus.err_o), 32'(0));
    check("err_still_idle", 32'(bus.busy_o), 32'(0));

    // enable dropped while the third of five symbols is offered
    clear_counts();
    push_frame(5, 1'b0);
    drv.start = 1'b1; drv.len = 5; drv.tbe = 1'b0; drv.pm = 0;
    tick();
    drv.start = 1'b0; drv.bmv = 1'b1;
    for (int c = 0; c < 50 && n_acc < 2; c++) tick();
    check("abort_two_accepted", 32'(n_acc), 32'(2));
    drv.en = 1'b0;
    tick();
    check("abort_acs_en_now", 32'(bus.acs_en_o), 32'(0));
    check("abort_ready_now", 32'(bus.bm_ready_o), 32'(0));
    check("abort_busy_until_edge", 32'(bus.busy_o), 32'(1));
    tick();
    check("abort_outputs_idle", outs_vec(), 32'(0));
    drv.en = 1'b1; drv.bmv = 1'b0;
    repeat (3) tick();
    check("abort_no_done", 32'(n_done), 32'(0));
    check("abort_no_tb_start", 32'(n_tbs), 32'(0));
    check("abort_writes", 32'(n_wr), 32'(1));
    exp_addr_q.delete();
    exp_rn_q.delete();
    run_frame(vecs[0]);

    // reset pulse while draining the last symbol
    clear_counts();
    push_frame(3, 1'b0);
    drv.start = 1'b1; drv.len = 3; drv.tbe = 1'b0; drv.pm = 0;
    tick();
    drv.start = 1'b0; drv.bmv = 1'b1;
    for (int c = 0; c < 50 && n_acc < 3; c++) tick();
    check("drain_three_accepted", 32'(n_acc), 32'(3));
    drv.bmv = 1'b0; drv.rst_n = 1'b0;
    tick();
    drv.rst_n = 1'b1;
    tick();
    check("drain_reset_outputs", outs_vec(), 32'(0));
    repeat (3) tick();
    check("drain_reset_no_tb_start", 32'(n_tbs), 32'(0));
    check("drain_reset_no_done", 32'(n_done), 32'(0));
    check("drain_reset_writes", 32'(n_wr), 32'(2));
    check("drain_reset_idle", 32'(bus.busy_o), 32'(0));
    exp_addr_q.delete();
    exp_rn_q.delete();
    run_frame(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
